seq_gen_sched: RTL and testbench

SEQ_GEN_SCHED -- requirements
Module: seq_gen_sched

---
 rtl/seq_gen_sched_if.sv | 14 +
 rtl/seq_gen_sched.sv | 83 ++++++++
 tb/tb_seq_gen_sched.sv | 132 +++++++++++++
 3 files changed

// File: rtl/seq_gen_sched_if.sv
// seq_gen_sched_if: request, pause and jump inputs plus generator control and grant status
interface seq_gen_sched_if;
    logic [3:0] req, hold, jump, grant;
    logic [1:0] owner;
    logic seq_terminal, gen_restart, gen_pause, gen_goto_third, busy, done, timeout;
    modport master (
        output req, hold, jump, seq_terminal,
        input  grant, owner, gen_restart, gen_pause, gen_goto_third, busy, done, timeout
    );
    modport slave (
        input  req, hold, jump, seq_terminal,
        output grant, owner, gen_restart, gen_pause, gen_goto_third, busy, done, timeout
    );
endinterface

// File: rtl/seq_gen_sched.sv
// seq_gen_sched: round-robin owner of a shared sequence generator; hold timeout under SEQ_SCHED_TIMEOUT_EN
module seq_gen_sched #(
    parameter int BURST_LEN  = 5,
    parameter int HOLD_LIMIT = 15
) (
    input logic clk,
    input logic reset,
    seq_gen_sched_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, RELEASE} state_t;
    state_t state_q, state_d;
    logic [1:0] owner_q, owner_d, last_q, last_d, win;
    logic [3:0] step_q, step_d;
    logic own_hold, tmo;
    assign own_hold = bus.hold[owner_q];
`ifdef SEQ_SCHED_TIMEOUT_EN
    logic [3:0] hold_q, hold_d;
    logic timeout_q, timeout_d;
    assign tmo = state_q == RUN && own_hold && hold_q == 4'(HOLD_LIMIT - 1);
    // consecutive paused cycles; timeout only counts when no abort outranks it
    always_comb begin
        hold_d = (state_q == RUN && own_hold) ? hold_q + 4'd1 : 4'd0;
        timeout_d = tmo && bus.req[owner_q];
    end
    // hold counter and timeout flag registers
    always_ff @(posedge clk) begin
        hold_q <= reset ? 4'd0 : hold_d;
        timeout_q <= reset ? 1'b0 : timeout_d;
    end
    assign bus.timeout = timeout_q;
`else
    assign tmo = 1'b0;
    assign bus.timeout = 1'b0;
`endif
    // first requester at or after last owner + 1, wrapping
    always_comb begin
        win = last_q + 2'd1;
        for (int i = 3; i >= 0; i--)
            if (bus.req[last_q + 2'(i + 1)]) win = last_q + 2'(i + 1);
    end
    // next state, owner bookkeeping and unpaused step count
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d = last_q;
        step_d = state_q == RUN ? step_q + {3'd0, ~own_hold} : 4'd0;
        case (state_q)
            IDLE: if (|bus.req) begin
                state_d = RUN;
                owner_d = win;
            end
            RUN: if (!bus.req[owner_q] || tmo ||
                     (!own_hold && (bus.seq_terminal || step_q == 4'(BURST_LEN - 1))))
                state_d = RELEASE;
            RELEASE: begin
                state_d = IDLE;
                last_d = owner_q;
            end
            default: state_d = IDLE;
        endcase
    end
    // state registers; reset outranks everything, so no done follows a mid-RUN reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= 2'd0;
            last_q <= 2'd3;
            step_q <= 4'd0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q <= last_d;
            step_q <= step_d;
        end
    end
    assign bus.busy = state_q == RUN;
    assign bus.done = state_q == RELEASE;
    assign bus.grant = bus.busy ? 4'b0001 << owner_q : 4'b0000;
    assign bus.owner = owner_q;
    assign bus.gen_restart = !bus.busy;
    assign bus.gen_pause = bus.busy && own_hold;
    assign bus.gen_goto_third = bus.busy && bus.jump[owner_q] && !own_hold;
endmodule

// File: tb/tb_seq_gen_sched.sv
// tb_seq_gen_sched: directed scenarios with a per-cycle scoreboard of grant-phase outputs
module tb_seq_gen_sched;
    logic clk = 1'b0, reset = 1'b1;
    always #5 clk = ~clk;
    seq_gen_sched_if bus();
    seq_gen_sched #(.BURST_LEN(5), .HOLD_LIMIT(4)) dut (.clk(clk), .reset(reset), .bus(bus));
    typedef struct packed {
        logic [3:0] grant;
        logic [1:0] owner;
        logic pause, go3, restart, done, tmo;
    } rec_t;
    rec_t q[$];
    int checks = 0, fails = 0;
    rec_t act, e;
    // monitor: every RUN or RELEASE cycle must match the next expected record
    always @(negedge clk) if (bus.busy || bus.done) begin
        act = '{bus.grant, bus.owner, bus.gen_pause, bus.gen_goto_third, bus.gen_restart, bus.done, bus.timeout};
        checks++;
        if (q.size() == 0) begin
            fails++;
            $display("FAIL cycle_rec: got grant=%b owner=%0d pause=%b goto=%b restart=%b done=%b timeout=%b, required no activity",
                     act.grant, act.owner, act.pause, act.go3, act.restart, act.done, act.tmo);
        end else begin
            e = q.pop_front();
            if (act !== e) begin
                fails++;
                $display("FAIL cycle_rec @%0t: got grant=%b owner=%0d pause=%b goto=%b restart=%b done=%b timeout=%b, required grant=%b owner=%0d pause=%b goto=%b restart=%b done=%b timeout=%b",
                         $time, act.grant, act.owner, act.pause, act.go3, act.restart, act.done, act.tmo,
                         e.grant, e.owner, e.pause, e.go3, e.restart, e.done, e.tmo);
            end
        end
    end
    task automatic cyc(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic chk(string n, logic [7:0] a, logic [7:0] r);
        checks++;
        if (a !== r) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", n, a, r);
        end
    endtask
    task automatic push(logic [3:0] g, logic [1:0] o, logic p, logic j, logic d, logic t, int n);
        repeat (n) q.push_back('{g, o, p, j, d, d, t});
    endtask
    task automatic run(logic [1:0] o, int n);
        push(4'b0001 << o, o, 1'b0, 1'b0, 1'b0, 1'b0, n);
    endtask
    task automatic rel(logic [1:0] o, logic t);
        push(4'b0000, o, 1'b0, 1'b0, 1'b1, t, 1);
    endtask
    task automatic burst2(logic [3:0] r, logic [1:0] o1, logic [1:0] o2);
        run(o1, 5); rel(o1, 1'b0); run(o2, 5); rel(o2, 1'b0);
        bus.req = r;
        cyc(13);
        bus.req = 4'b0000;
        cyc(2);
    endtask
    initial begin
        bus.req = 4'b0000; bus.hold = 4'b0000; bus.jump = 4'b0000; bus.seq_terminal = 1'b0;
        cyc(2);
        chk("rst_grant", bus.grant, 8'h0);
        chk("rst_owner", bus.owner, 8'h0);
        chk("rst_busy", bus.busy, 8'h0);
        chk("rst_done", bus.done, 8'h0);
        chk("rst_timeout", bus.timeout, 8'h0);
        chk("rst_restart", bus.gen_restart, 8'h1);
        chk("rst_pause", bus.gen_pause, 8'h0);
        chk("rst_goto", bus.gen_goto_third, 8'h0);
        reset = 1'b0;
        burst2(4'b0101, 2'd0, 2'd2);
        run(2, 2); push(4'b0100, 2, 1'b1, 1'b0, 1'b0, 1'b0, 3);
        push(4'b0100, 2, 1'b0, 1'b1, 1'b0, 1'b0, 1); run(2, 2); rel(2, 1'b0);
        bus.req = 4'b0100;
        cyc(3);
        bus.hold = 4'b0100; bus.jump = 4'b0100;
        cyc(3);
        bus.hold = 4'b0000;
        cyc(1);
        bus.jump = 4'b0000;
        cyc(2);
        bus.req = 4'b0000;
        cyc(2);
        run(1, 2); rel(1, 1'b0);
        bus.req = 4'b0010;
        cyc(2);
        bus.seq_terminal = 1'b1;
        cyc(1);
        bus.seq_terminal = 1'b0; bus.req = 4'b0000;
        cyc(2);
        run(1, 3); rel(1, 1'b0);
        bus.req = 4'b0010;
        cyc(3);
        bus.req = 4'b0000;
        cyc(3);
        burst2(4'b1010, 2'd3, 2'd1);
`ifdef SEQ_SCHED_TIMEOUT_EN
        push(4'b0100, 2, 1'b1, 1'b0, 1'b0, 1'b0, 4); rel(2, 1'b1);
        bus.req = 4'b0100; bus.hold = 4'b0100;
        cyc(5);
        bus.req = 4'b0000; bus.hold = 4'b0000;
        cyc(2);
`else
        push(4'b0100, 2, 1'b1, 1'b0, 1'b0, 1'b0, 20); run(2, 1); rel(2, 1'b0);
        bus.req = 4'b0100; bus.hold = 4'b0100;
        cyc(21);
        bus.req = 4'b0000; bus.hold = 4'b0000;
        cyc(3);
`endif
        run(1, 2);
        bus.req = 4'b0010;
        cyc(2);
        reset = 1'b1; bus.req = 4'b0000;
        cyc(1);
        chk("mid_rst_grant", bus.grant, 8'h0);
        chk("mid_rst_done", bus.done, 8'h0);
        chk("mid_rst_owner", bus.owner, 8'h0);
        chk("mid_rst_busy", bus.busy, 8'h0);
        chk("mid_rst_restart", bus.gen_restart, 8'h1);
        reset = 1'b0;
        cyc(1);
        run(0, 5); rel(0, 1'b0);
        bus.req = 4'b0011;
        cyc(6);
        bus.req = 4'b0000;
        cyc(2);
        chk("pending_records", 8'(q.size()), 8'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
